// File: rtl/pipe_stall_ctrl_pkg.sv
// Purpose : shared stall masks, exception codes and FSM state type for the pipeline controller.
// Latency : n/a (definitions only).
// Backpressure: n/a; stall bit order is [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;  // hold PC, IF, ID
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;  // hold PC, IF, ID, EX

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_multi_cycle_counter.sv
// Purpose : down-counter that tracks remaining stall cycles of a multi-cycle EX op.
// Latency : load/decrement take effect on the next edge; last_o is combinational from the count.
// Backpressure: none; clr beats load, load beats dec.
// Ports: clk, rst (sync, active-high), clr_i, load_i/load_val_i, dec_i, last_o (count == 1).
module pipe_stall_ctrl_multi_cycle_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Purpose : merges stage stall requests, sequences multi-cycle EX ops, flushes/redirects on exception or eret.
// Latency : stall/flush/new_pc/busy are same-cycle combinational; state and count update on the next edge.
// Backpressure: stall vector holds PC..EX while a multi-cycle op runs; exception flush overrides every stall.
// Ports: clk, rst (sync, active-high), stallreq_from_id/ex, ex_multi_start/cycles, excepttype_i, cp0_epc_i
//        -> stall[5:0], flush, new_pc, busy. Optional macro STALL_PERF_CNT_EN adds perf_stall_cycles
//        (cycles with stall and no flush) and perf_flush_count (flush cycles); both wrap.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int          CNT_W      = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_id,
  input  logic               stallreq_from_ex,
  input  logic               ex_multi_start,
  input  logic [CNT_W-1:0]   ex_multi_cycles,
  input  logic [31:0]        excepttype_i,
  input  logic [31:0]        cp0_epc_i,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0]        perf_stall_cycles,
  output logic [15:0]        perf_flush_count,
`endif
  output logic               busy
);

  ctrl_state_e state_q, state_d;
  logic        start_ok;
  logic        cnt_clr, cnt_load, cnt_dec, cnt_last;

  // A start with a zero length, or one arriving while already in MULTI, is ignored.
  assign start_ok = (state_q == RUN) && ex_multi_start && (ex_multi_cycles != '0);
  assign busy     = (rst != RstEnable) && ((state_q == MULTI) || start_ok);

  always_comb begin
    state_d  = state_q;
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = ZeroWord;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (rst == RstEnable) begin
      state_d = RUN;
      cnt_clr = 1'b1;
    end else if (excepttype_i != EXC_NONE) begin
      // Exception aborts any running op and discards a same-cycle start.
      flush   = 1'b1;
      new_pc  = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
      state_d = RUN;
      cnt_clr = 1'b1;
    end else if (state_q == MULTI) begin
      stall   = STALL_EX;
      cnt_dec = 1'b1;
      if (cnt_last) state_d = RUN;
    end else if (start_ok) begin
      // The start cycle is stall cycle 1, so MULTI only needs N-1 more.
      stall = STALL_EX;
      if (ex_multi_cycles != CNT_W'(1)) begin
        cnt_load = 1'b1;
        state_d  = MULTI;
      end
    end else if (stallreq_from_ex) begin
      stall = STALL_EX;
    end else if (stallreq_from_id) begin
      stall = STALL_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_stall_ctrl_multi_cycle_counter #(.CNT_W(CNT_W)) u_multi_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (ex_multi_cycles - CNT_W'(1)),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if ((stall != STALL_NONE) && !flush) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

  // A new start while a multi-cycle op is counting is a protocol error upstream.
  always_ff @(posedge clk) begin
    if ((rst != RstEnable) && (state_q == MULTI) && (excepttype_i == EXC_NONE)) begin
      assert (!ex_multi_start);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Purpose : directed self-checking bench for pipe_stall_ctrl.
// Latency : inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_id, stallreq_from_ex, ex_multi_start;
  logic [5:0]  ex_multi_cycles;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush, busy;
  logic [31:0] new_pc;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .ex_multi_start   (ex_multi_start),
    .ex_multi_cycles  (ex_multi_cycles),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
`ifdef STALL_PERF_CNT_EN
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count (perf_flush_count),
`endif
    .busy             (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all four primary outputs of the current cycle.
  task automatic chk_all(input string tag, input logic [5:0] e_stall, input logic e_flush,
                         input logic [31:0] e_pc, input logic e_busy);
    chk({tag, ".stall"}, {26'd0, stall}, {26'd0, e_stall});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
    chk({tag, ".new_pc"}, new_pc, e_pc);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stallreq_from_id = 1'b0;
    stallreq_from_ex = 1'b0;
    ex_multi_start   = 1'b0;
    ex_multi_cycles  = 6'd0;
    excepttype_i     = 32'h0;
    cp0_epc_i        = 32'h0;
  endtask

  initial begin
    // Reset held 3 cycles with every request asserted: outputs forced to zero.
    rst = 1'b1;
    stallreq_from_id = 1'b1;
    stallreq_from_ex = 1'b1;
    ex_multi_start   = 1'b1;
    ex_multi_cycles  = 6'd5;
    excepttype_i     = 32'h0000_000a;
    cp0_epc_i        = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk_all($sformatf("reset%0d", i), 6'b000000, 1'b0, 32'h0, 1'b0);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    sample();
    chk_all("post_reset", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Load-use: one cycle of 000111 only.
    next_cycle();
    stallreq_from_id = 1'b1;
    sample();
    chk_all("load_use", 6'b000111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    stallreq_from_id = 1'b0;
    sample();
    chk_all("load_use_after", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Multi-cycle N=4: exactly 4 stalled busy cycles.
    next_cycle();
    ex_multi_start  = 1'b1;
    ex_multi_cycles = 6'd4;
    for (int i = 1; i <= 4; i++) begin
      sample();
      chk_all($sformatf("multi4_c%0d", i), 6'b001111, 1'b0, 32'h0, 1'b1);
      next_cycle();
      ex_multi_start  = 1'b0;
      ex_multi_cycles = 6'd0;
    end
    sample();
    chk_all("multi4_done", 6'b000000, 1'b0, 32'h0, 1'b0);
`ifdef STALL_PERF_CNT_EN
    chk("perf_stall_5", perf_stall_cycles, 32'd5);
    chk("perf_flush_0", {16'd0, perf_flush_count}, 32'd0);
`endif

    // Multi-cycle N=1: exactly one stalled cycle.
    next_cycle();
    ex_multi_start  = 1'b1;
    ex_multi_cycles = 6'd1;
    sample();
    chk_all("multi1_c1", 6'b001111, 1'b0, 32'h0, 1'b1);
    next_cycle();
    idle_inputs();
    sample();
    chk_all("multi1_done", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Multi-cycle N=0: ignored.
    next_cycle();
    ex_multi_start  = 1'b1;
    ex_multi_cycles = 6'd0;
    sample();
    chk_all("multi0", 6'b000000, 1'b0, 32'h0, 1'b0);
    next_cycle();
    idle_inputs();
    sample();
    chk_all("multi0_after", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Exception on cycle 3 of an N=10 op: flush to vector, op aborted.
    next_cycle();
    ex_multi_start  = 1'b1;
    ex_multi_cycles = 6'd10;
    sample();
    chk_all("exc_mid_c1", 6'b001111, 1'b0, 32'h0, 1'b1);
    next_cycle();
    idle_inputs();
    sample();
    chk_all("exc_mid_c2", 6'b001111, 1'b0, 32'h0, 1'b1);
    next_cycle();
    excepttype_i = 32'h0000_000a;
    sample();
    chk("exc_mid_c3.stall", {26'd0, stall}, 32'h0);
    chk("exc_mid_c3.flush", {31'd0, flush}, 32'd1);
    chk("exc_mid_c3.new_pc", new_pc, 32'h0000_0020);
    next_cycle();
    idle_inputs();
    sample();
    chk_all("exc_mid_c4", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Eret: redirect to EPC for one cycle.
    next_cycle();
    excepttype_i = 32'h0000_000e;
    cp0_epc_i    = 32'hbfc0_0104;
    sample();
    chk_all("eret", 6'b000000, 1'b1, 32'hbfc0_0104, 1'b0);
    next_cycle();
    idle_inputs();
    sample();
    chk_all("eret_after", 6'b000000, 1'b0, 32'h0, 1'b0);
`ifdef STALL_PERF_CNT_EN
    chk("perf_stall_8", perf_stall_cycles, 32'd8);
    chk("perf_flush_2", {16'd0, perf_flush_count}, 32'd2);
`endif

    // Simultaneous id+ex requests: superset mask.
    next_cycle();
    stallreq_from_id = 1'b1;
    stallreq_from_ex = 1'b1;
    sample();
    chk_all("id_and_ex", 6'b001111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    stallreq_from_id = 1'b0;
    sample();
    chk_all("ex_only", 6'b001111, 1'b0, 32'h0, 1'b0);

    // Exception beats stall requests.
    next_cycle();
    stallreq_from_id = 1'b1;
    excepttype_i     = 32'h0000_0008;
    sample();
    chk_all("exc_over_stall", 6'b000000, 1'b1, 32'h0000_0020, 1'b0);

    // Exception in the same cycle as a start: start discarded.
    next_cycle();
    idle_inputs();
    excepttype_i    = 32'h0000_0004;
    ex_multi_start  = 1'b1;
    ex_multi_cycles = 6'd3;
    sample();
    chk("exc_start.stall", {26'd0, stall}, 32'h0);
    chk("exc_start.flush", {31'd0, flush}, 32'd1);
    chk("exc_start.new_pc", new_pc, 32'h0000_0020);
    next_cycle();
    idle_inputs();
    sample();
    chk_all("exc_start_after", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Reset during MULTI N=20: outputs zero, nothing left over after release.
    next_cycle();
    ex_multi_start  = 1'b1;
    ex_multi_cycles = 6'd20;
    sample();
    chk_all("rst_multi_c1", 6'b001111, 1'b0, 32'h0, 1'b1);
    next_cycle();
    idle_inputs();
    sample();
    chk_all("rst_multi_c2", 6'b001111, 1'b0, 32'h0, 1'b1);
    next_cycle();
    rst = 1'b1;
    sample();
    chk_all("rst_multi_in_rst", 6'b000000, 1'b0, 32'h0, 1'b0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk_all($sformatf("rst_multi_after%0d", i), 6'b000000, 1'b0, 32'h0, 1'b0);
      next_cycle();
    end
`ifdef STALL_PERF_CNT_EN
    chk("perf_stall_rst", perf_stall_cycles, 32'd0);
    chk("perf_flush_rst", {16'd0, perf_flush_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage pipeline: IF/ID, ID/EX, EX/MEM, MEM/WB registers and the PC register.
- Merges per-stage stall requests, sequences multi-cycle EX operations (mult-acc, div) with an internal down-counter, and raises a flush with a redirect PC on exception or eret.
- Every pipeline register consumes its own bit of the stall vector plus the common flush.

Parameters:
- CNT_W, 6, width of multi-cycle count input and internal counter (max 63 cycles).
- EXC_VECTOR, 32'h00000020, redirect PC for all non-eret exceptions.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- stallreq_from_id  in  1  load-use hazard request, single cycle, level.
- stallreq_from_ex  in  1  generic EX stall request, level.
- ex_multi_start  in  1  pulse: EX begins a multi-cycle op this cycle.
- ex_multi_cycles  in  CNT_W  total stall cycles for that op, sampled with ex_multi_start.
- excepttype_i  in  32  exception code from MEM; 0 = none.
- cp0_epc_i  in  32  current EPC from CP0.
- stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1 = hold.
- flush  out  1  clear all pipeline registers.
- new_pc  out  32  redirect target, valid while flush=1.
- busy  out  1  high while a multi-cycle op is counting.
- Clock is clk; reset is rst, synchronous, active-high. No other clock or reset.

Behaviour:
- States: RUN, MULTI. Counter cnt (CNT_W bits).
- Reset: state=RUN, cnt=0. Outputs while rst=1: stall=6'b000000, flush=0, new_pc=0, busy=0.
- stall, flush and new_pc are combinational from state and inputs (same-cycle effect). State and cnt are registered.

Priority, highest first:
- 1. excepttype_i!=0:
  - flush=1, stall=0.
  - new_pc=cp0_epc_i if code==32'h0000000e (eret); otherwise EXC_VECTOR.
  - Next state RUN, cnt<=0; this aborts any MULTI op.
- 2. MULTI state, or RUN with ex_multi_start=1 and ex_multi_cycles>=1: stall=6'b001111.
- 3. stallreq_from_ex=1: stall=6'b001111.
- 4. stallreq_from_id=1: stall=6'b000111.
- 5. Otherwise stall=0, flush=0, new_pc=0.

Multi-cycle sequencing:
- RUN with start and N=ex_multi_cycles>=1:
  - The start cycle is stall cycle 1.
  - N=1: stay in RUN.
  - N>1: cnt<=N-1 and go to MULTI.
- MULTI: cnt decrements each cycle. The cycle in which cnt==1 is the last stalled cycle; next state is RUN with cnt=0.
- Total stall = exactly N cycles.
- N=0 with start: ignored, no stall.
- ex_multi_start asserted while in MULTI: ignored (protocol error; a sim assertion flags it).
- busy = (state==MULTI) || (RUN && start && N>=1).
- Simultaneous id+ex requests give 001111 (superset wins). An exception in the same cycle as start gives flush only; the start is discarded.
- rst asserted mid-MULTI: RUN and cnt=0 on the next edge; outputs are zero while rst=1.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - Adds output perf_stall_cycles (32).
  - Increments by 1 on every cycle with stall!=0 and flush=0.
  - Cleared by rst; wraps at 2^32-1 to 0.
  - Adds output perf_flush_count (16): increments on each flush cycle, wraps.
- Undefined: both ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared defines include: stall vector width 6, stall masks, and exception codes.
  - STALL_NONE=6'b000000, STALL_ID=6'b000111, STALL_EX=6'b001111.
  - EXC_ERET=32'h0000000e, EXC_NONE=32'h0.
  - Existing RstEnable, ZeroWord.
- One natural sub-module: multi_cycle_counter (load, decrement, last-cycle flag), instantiated once.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all requests high -> stall=000000, flush=0, new_pc=0, busy=0; after release, state is RUN.
- Load-use: stallreq_from_id=1 for 1 cycle -> stall=000111 in that cycle only, 000000 after.
- Multi-cycle: start with ex_multi_cycles=4 -> stall=001111 and busy=1 for exactly 4 consecutive cycles, then 000000. With ex_multi_cycles=1 -> exactly 1 cycle. With 0 -> none.
- Exception mid-op: start N=10, excepttype_i=32'h0000000a on cycle 3 -> that cycle flush=1, stall=000000, new_pc=32'h00000020; next cycle busy=0, no stall.
- Eret: excepttype_i=32'h0000000e, cp0_epc_i=32'hbfc00104 -> flush=1, new_pc=32'hbfc00104 for 1 cycle.
- Simultaneous: stallreq_from_id=1 and stallreq_from_ex=1 -> 001111. Reset asserted during MULTI N=20 -> all outputs 0 next cycle and no residual stall after release. With STALL_PERF_CNT_EN, perf_stall_cycles ends at the expected count (e.g. 5 after the load-use + N=4 sequence).
